// File: rtl/wrd_pkg.sv
// Shared definitions for the word-recognition decision path: FC output geometry
// and the argmax controller states.
package wrd_pkg;

    localparam int FC_NUM_CLASSES = 3;
    localparam int FC_I_BW        = 24;
    localparam int FC_IDX_BW      = $clog2(FC_NUM_CLASSES);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/argmax.sv
// Picks the index of the largest signed FC score in each framed stream of
// scores and hands one class index per frame to the wake stage.
module argmax
    import wrd_pkg::*;
#(
    parameter int I_BW        = FC_I_BW,
    parameter int NUM_CLASSES = FC_NUM_CLASSES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic signed [I_BW-1:0]    data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic [$clog2(NUM_CLASSES)-1:0] data_o,
    output logic                      valid_o,
    output logic                      last_o,
    input  logic                      ready_i,
    output logic                      err_o
);

    localparam int IDX_BW = $clog2(NUM_CLASSES);
    localparam logic [IDX_BW:0] LIMIT_CNT = (IDX_BW+1)'(NUM_CLASSES - 1);

    argmax_state_t          r_state;
    logic [IDX_BW:0]        r_count;
    logic signed [I_BW-1:0] r_max;
    logic [IDX_BW-1:0]      r_idx;
    logic [IDX_BW-1:0]      r_data;
    logic                   r_valid;
    logic                   r_err;

    logic                   w_take;
    logic                   w_at_limit;
    logic                   w_frame_end;
    logic                   w_len_err;
    logic [IDX_BW-1:0]      w_count_idx;
    logic [IDX_BW-1:0]      w_win;

    // Strict greater-than keeps the lower index on ties; the first beat always seeds.
    assign w_count_idx = r_count[IDX_BW-1:0];
    assign w_take      = (r_count == '0) || (data_i > r_max);
    assign w_win       = w_take ? w_count_idx : r_idx;
    assign w_at_limit  = (r_count == LIMIT_CNT);
    assign w_frame_end = last_i || w_at_limit;
    assign w_len_err   = last_i ^ w_at_limit;

    assign ready_o = (r_state == ACCUM) && !rst_i;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_valid;
    assign err_o   = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ACCUM;
            r_count <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (valid_i) begin
                        if (w_take) begin
                            r_max <= data_i;
                            r_idx <= w_count_idx;
                        end
                        if (w_frame_end) begin
                            r_data  <= w_win;
                            r_valid <= 1'b1;
                            r_err   <= w_len_err;
                            r_count <= '0;
                            r_state <= OUT;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax.sv
// Directed scoreboard bench for argmax: expected indices/error flags are queued
// as each frame is driven and retired when the result appears.
module tb_argmax;
    import wrd_pkg::*;

    localparam int IBW  = FC_I_BW;
    localparam int IDXW = FC_IDX_BW;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            err;
    } exp_t;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic signed [IBW-1:0] data_i;
    logic                  valid_i;
    logic                  last_i;
    logic                  ready_o;
    logic [IDXW-1:0]       data_o;
    logic                  valid_o;
    logic                  last_o;
    logic                  ready_i;
    logic                  err_o;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    exp_t expQ[$];
    logic prevValid = 1'b0;

    argmax dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input int idx, input logic err);
        exp_t e;
        e.idx = IDXW'(idx);
        e.err = err;
        expQ.push_back(e);
    endtask

    // Drive one beat, wait (bounded) for acceptance, optionally check result latency.
    task automatic applyStimulus(input int d, input logic l, input logic expectEnd);
        int waitCycles = 0;
        valid_i = 1'b1;
        data_i  = IBW'(d);
        last_i  = l;
        @(negedge clk_i);
        while (!ready_o && waitCycles < 50) begin
            @(negedge clk_i);
            waitCycles++;
        end
        checkOutput("acceptWait", 32'(waitCycles < 50), 1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        if (expectEnd) checkOutput("latency", 32'(valid_o), 1);
    endtask

    // Result monitor: compares each new result against the scoreboard head.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1 && !prevValid) begin
            checkOutput("resultExpected", 32'(expQ.size() > 0), 1);
            checkOutput("lastOnResult", 32'(last_o), 1);
            if (expQ.size() > 0) begin
                checkOutput("resultIdx", 32'(data_o), 32'(expQ[0].idx));
                checkOutput("resultErr", 32'(err_o), 32'(expQ[0].err));
            end
        end else begin
            checkOutput("errQuiet", 32'(err_o), 0);
            if (valid_o === 1'b1 && expQ.size() > 0)
                checkOutput("heldIdx", 32'(data_o), 32'(expQ[0].idx));
        end
        if (valid_o === 1'b1 && ready_i && !rst_i && expQ.size() > 0)
            void'(expQ.pop_front());
        prevValid = (valid_o === 1'b1);
    end

    initial begin
        int endCycle[3];

        rst_i   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rstReady", 32'(ready_o), 0);
        checkOutput("rstValid", 32'(valid_o), 0);
        checkOutput("rstData", 32'(data_o), 0);
        checkOutput("rstErr", 32'(err_o), 0);
        checkOutput("rstLast", 32'(last_o), 0);
        rst_i = 1'b0;
        #1;
        checkOutput("readyAfterRst", 32'(ready_o), 1);

        $display("[TB] basic frame [-5, 20, 7]");
        pushExpect(1, 1'b0);
        applyStimulus(-5, 1'b0, 1'b0);
        applyStimulus(20, 1'b0, 1'b0);
        applyStimulus(7, 1'b1, 1'b1);

        $display("[TB] signed tie and extremes");
        pushExpect(1, 1'b0);
        applyStimulus(-100, 1'b0, 1'b0);
        applyStimulus(-3, 1'b0, 1'b0);
        applyStimulus(-3, 1'b1, 1'b1);
        pushExpect(0, 1'b0);
        applyStimulus(8388607, 1'b0, 1'b0);
        applyStimulus(-8388608, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1);

        $display("[TB] downstream stall");
        applyStimulus(5, 1'b0, 1'b0);
        ready_i = 1'b0;
        pushExpect(2, 1'b0);
        applyStimulus(6, 1'b0, 1'b0);
        applyStimulus(9, 1'b1, 1'b1);
        valid_i = 1'b1;
        data_i  = IBW'(11);
        last_i  = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("stallReady", 32'(ready_o), 0);
            checkOutput("stallValid", 32'(valid_o), 1);
            checkOutput("stallData", 32'(data_o), 2);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("postHsReady", 32'(ready_o), 1);
        checkOutput("postHsValid", 32'(valid_o), 0);
        applyStimulus(11, 1'b0, 1'b0);
        pushExpect(2, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(30, 1'b1, 1'b1);

        $display("[TB] short and long frames");
        pushExpect(1, 1'b1);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(9, 1'b1, 1'b1);
        pushExpect(2, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b1);
        pushExpect(2, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(6, 1'b1, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(50, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        checkOutput("rstReadyComb", 32'(ready_o), 0);
        @(posedge clk_i);
        #1;
        checkOutput("midRstValid", 32'(valid_o), 0);
        checkOutput("midRstData", 32'(data_o), 0);
        checkOutput("midRstErr", 32'(err_o), 0);
        checkOutput("midRstReady", 32'(ready_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pushExpect(0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b1);

        $display("[TB] back-to-back frames");
        pushExpect(2, 1'b0);
        pushExpect(0, 1'b0);
        pushExpect(1, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 1'b1);
        endCycle[0] = cycle;
        applyStimulus(9, 1'b0, 1'b0);
        applyStimulus(8, 1'b0, 1'b0);
        applyStimulus(7, 1'b1, 1'b1);
        endCycle[1] = cycle;
        applyStimulus(4, 1'b0, 1'b0);
        applyStimulus(6, 1'b0, 1'b0);
        applyStimulus(5, 1'b1, 1'b1);
        endCycle[2] = cycle;
        checkOutput("throughput01", 32'(endCycle[1] - endCycle[0]), 4);
        checkOutput("throughput12", 32'(endCycle[2] - endCycle[1]), 4);

        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
